// File: rtl/nor_reduce_pipe.sv
// -----------------------------------------------------------------------------
// nor_reduce_pipe
//
// Pipelined, multi-lane OR/NOR reduction with valid/ready flow control and a
// saturating event counter.
//
// Each of LANES lanes reduces a WIDTH-bit slice of A to a single bit. The
// result is NOR when INVERT=1 and OR when INVERT=0. The reduction tree is
// spread across STAGES register stages:
//   - Stage 1 registers P = 2^(STAGES-1) partial ORs per lane. Each partial
//     covers a chunk of C = ceil(WIDTH/P) input bits. The last chunk may be
//     short, and chunks entirely past WIDTH contribute zero.
//   - Each later stage ORs adjacent pairs of partials, halving their count.
//   - The final stage holds one bit per lane. The optional inversion is
//     applied as that stage is loaded, so Y comes straight from a register.
//
// Flow control is a chain of elastic stages. A stage is ready when it is
// empty or when every stage downstream of it can move. This lets bubbles
// collapse and sustains one beat per cycle while OUT_READY is high.
//
// Parameters:
//   WIDTH  - input bits reduced per lane (>= 2^(STAGES-1))
//   LANES  - number of independent lanes
//   STAGES - pipeline depth and latency (1..4)
//   INVERT - 1: NOR reduction, 0: OR reduction
//   CNT_W  - event counter width
//
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   asynchronous active-high reset
//   IN_VALID  in   input beat valid
//   IN_READY  out  a beat is accepted this cycle if IN_VALID is high
//   A         in   LANES*WIDTH; lane i is A[i*WIDTH +: WIDTH]
//   OUT_VALID out  Y holds a valid result
//   OUT_READY in   downstream takes Y this cycle
//   Y         out  LANES per-lane reduction results
//   CLR_CNT   in   synchronous clear of EVT_CNT (wins over increment)
//   EVT_CNT   out  saturating count of output transfers with Y != 0
// -----------------------------------------------------------------------------
module nor_reduce_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int INVERT = 1,
    parameter int CNT_W  = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [LANES*WIDTH-1:0]   A,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [LANES-1:0]         Y,
    input  logic                     CLR_CNT,
    output logic [CNT_W-1:0]         EVT_CNT
);

    // Partials per lane registered by stage 1, and bits per partial.
    localparam int P = (STAGES >= 1) ? 2 ** (STAGES - 1) : 1;
    localparam int C = (WIDTH + P - 1) / P;

    // All stage partials share one flat vector. Stage s (0-based) holds
    // np = P >> s partials per lane. It starts at bit offset
    // LANES * (2P - 2np), and lane i of that stage sits at base + i*np.
    localparam int TOT_BITS = LANES * (2 * P - 1);
    localparam int Y_BASE   = LANES * (2 * P - 2);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (STAGES < 1 || STAGES > 4 || WIDTH < P) begin : g_bad_params
        $error("nor_reduce_pipe: need 1 <= STAGES <= 4 and WIDTH >= 2^(STAGES-1)");
    end

    // -------------------------------------------------------------------------
    // Flow control
    // -------------------------------------------------------------------------
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] stage_ready;
    logic [STAGES-1:0] stage_load;
    logic [STAGES:0]   valid_chain;   // valid_chain[k] is the upstream valid of stage k

    assign valid_chain = {valid_q, IN_VALID};

    // NOTE: every signal written in an always_comb block gets a default value
    // first. A path that leaves a signal unassigned would infer a latch.
    always_comb begin
        logic all_full;
        all_full    = 1'b1;
        stage_ready = '0;
        valid_d     = valid_q;
        // Stage k stalls only when it and every stage after it are full and
        // the output is not taken. Walk from the output back to the input.
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full       = all_full & valid_q[k];
            stage_ready[k] = ~all_full | OUT_READY;
        end
        for (int k = 0; k < STAGES; k++) begin
            if (stage_ready[k]) begin
                valid_d[k] = valid_chain[k];
            end
        end
    end

    // Data is only captured alongside a valid beat. An empty stage keeps its
    // old partials, which are never observed because its valid bit is low.
    assign stage_load = stage_ready & valid_chain[STAGES-1:0];

    // -------------------------------------------------------------------------
    // Reduction tree
    // -------------------------------------------------------------------------
    logic [TOT_BITS-1:0] part_q, part_d;

    always_comb begin
        logic acc;
        int   np;
        int   base;
        int   pbase;
        acc    = 1'b0;
        np     = 0;
        base   = 0;
        pbase  = 0;
        part_d = part_q;

        // Stage 1: chunked OR straight from the lane inputs. Bits past WIDTH
        // are skipped, so short or empty chunks act as zero padding.
        if (stage_load[0]) begin
            for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < P; j++) begin
                    acc = 1'b0;
                    for (int b = 0; b < C; b++) begin
                        if (j * C + b < WIDTH) begin
                            acc = acc | A[i * WIDTH + j * C + b];
                        end
                    end
                    if (STAGES == 1 && INVERT != 0) begin
                        acc = ~acc;
                    end
                    part_d[i * P + j] = acc;
                end
            end
        end

        // Later stages: pairwise OR of the previous stage's partials.
        for (int s = 1; s < STAGES; s++) begin
            np    = P >> s;
            base  = LANES * (2 * P - 2 * np);
            pbase = LANES * (2 * P - 4 * np);
            if (stage_load[s]) begin
                for (int i = 0; i < LANES; i++) begin
                    for (int j = 0; j < np; j++) begin
                        acc = part_q[pbase + i * 2 * np + 2 * j]
                            | part_q[pbase + i * 2 * np + 2 * j + 1];
                        if (s == STAGES - 1 && INVERT != 0) begin
                            acc = ~acc;
                        end
                        part_d[base + i * np + j] = acc;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Event counter
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_xfer;

    assign out_xfer = valid_q[STAGES-1] & OUT_READY;

    always_comb begin
        cnt_d = cnt_q;
        if (CLR_CNT) begin
            cnt_d = '0;
        end else if (out_xfer && (|part_q[Y_BASE +: LANES]) && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples pre-edge values, whatever order the statements are in.
    // The partial registers are reset together with the valid bits. This
    // keeps Y at zero from reset until the first result arrives.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
        end
    end

    assign IN_READY  = stage_ready[0];
    assign OUT_VALID = valid_q[STAGES-1];
    assign Y         = part_q[Y_BASE +: LANES];
    assign EVT_CNT   = cnt_q;

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// -----------------------------------------------------------------------------
// tb_nor_reduce_pipe
//
// Five instances share one stimulus stream:
//   0: defaults (WIDTH 8, STAGES 2, NOR, CNT_W 8)
//   1: INVERT=0 (OR)
//   2: CNT_W=2 (saturation)
//   3: WIDTH=5, STAGES=3 (odd chunking), driven from A[19:0]
//   4: STAGES=4 (one bit per stage-1 chunk)
// Each instance has its own scoreboard queue. An expected Y is pushed when
// that instance accepts a beat, and popped when it transfers a result.
// -----------------------------------------------------------------------------
module tb_nor_reduce_pipe;

    localparam int NI = 5;
    localparam int STG [NI] = '{2, 2, 2, 3, 4};
    localparam int CW  [NI] = '{8, 8, 2, 8, 8};
    localparam int WD  [NI] = '{8, 8, 8, 5, 8};
    localparam bit INV [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        OUT_READY;
    logic        CLR_CNT;
    logic [31:0] a;

    logic        ir  [NI];
    logic        ov  [NI];
    logic [3:0]  y   [NI];
    logic [7:0]  cnt [NI];
    logic [1:0]  cnt_small;

    assign cnt[2] = {6'd0, cnt_small};

    always #5 CLK = ~CLK;

    nor_reduce_pipe u_def (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[0]), .A(a),
        .OUT_VALID(ov[0]), .OUT_READY(OUT_READY), .Y(y[0]),
        .CLR_CNT(CLR_CNT), .EVT_CNT(cnt[0]));

    nor_reduce_pipe #(.INVERT(0)) u_or (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[1]), .A(a),
        .OUT_VALID(ov[1]), .OUT_READY(OUT_READY), .Y(y[1]),
        .CLR_CNT(CLR_CNT), .EVT_CNT(cnt[1]));

    nor_reduce_pipe #(.CNT_W(2)) u_cnt (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[2]), .A(a),
        .OUT_VALID(ov[2]), .OUT_READY(OUT_READY), .Y(y[2]),
        .CLR_CNT(CLR_CNT), .EVT_CNT(cnt_small));

    nor_reduce_pipe #(.WIDTH(5), .STAGES(3)) u_odd (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[3]), .A(a[19:0]),
        .OUT_VALID(ov[3]), .OUT_READY(OUT_READY), .Y(y[3]),
        .CLR_CNT(CLR_CNT), .EVT_CNT(cnt[3]));

    nor_reduce_pipe #(.STAGES(4)) u_s4 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(ir[4]), .A(a),
        .OUT_VALID(ov[4]), .OUT_READY(OUT_READY), .Y(y[4]),
        .CLR_CNT(CLR_CNT), .EVT_CNT(cnt[4]));

    typedef struct {
        logic [3:0] y;
        int         t;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  y_nor;
        logic [3:0]  y_or;
    } vec_t;

    exp_t sb [NI][$];
    int   exp_cnt [NI];
    int   cyc;
    int   n_chk;
    int   n_pass;
    bit   lat_on;
    bit   acc0;
    vec_t tab [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Plain per-lane reduction over w-bit lanes. Chunking does not change an OR.
    function automatic logic [3:0] ref_y(input logic [31:0] av, input int w, input bit iv);
        logic [3:0] r;
        logic       any;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            any = 1'b0;
            for (int b = 0; b < w; b++) begin
                any = any | av[i * w + b];
            end
            r[i] = any ^ iv;
        end
        return r;
    endfunction

    // One cycle: drive inputs just after a falling edge, check outputs,
    // update the scoreboards for the coming rising edge, and wait for the
    // next falling edge.
    task automatic step(input bit v, input logic [31:0] av, input bit ordy, input bit clr,
                        input bit use_tab, input logic [3:0] t_nor, input logic [3:0] t_or);
        logic [3:0] e;
        bit         exp_ov;
        bit         exp_ir;
        int         maxc;
        bit         hit;
        IN_VALID  = v;
        a         = av;
        OUT_READY = ordy;
        CLR_CNT   = clr;
        #1;
        acc0 = v && ir[0];
        for (int k = 0; k < NI; k++) begin
            check($sformatf("inst%0d evt_cnt", k), {24'd0, cnt[k]}, exp_cnt[k]);
            exp_ir = !(sb[k].size() == STG[k] && !ordy);
            check($sformatf("inst%0d in_ready", k), {31'd0, ir[k]}, {31'd0, exp_ir});
            if (lat_on) begin
                exp_ov = (sb[k].size() > 0) && (cyc - sb[k][0].t >= STG[k]);
                check($sformatf("inst%0d out_valid latency", k), {31'd0, ov[k]}, {31'd0, exp_ov});
            end else if (sb[k].size() == 0) begin
                check($sformatf("inst%0d out_valid empty", k), {31'd0, ov[k]}, 32'd0);
            end
            hit = 1'b0;
            if (ov[k] && sb[k].size() > 0) begin
                check($sformatf("inst%0d y", k), {28'd0, y[k]}, {28'd0, sb[k][0].y});
                if (ordy) begin
                    hit = |sb[k][0].y;
                    void'(sb[k].pop_front());
                end
            end
            maxc = (1 << CW[k]) - 1;
            if (clr) begin
                exp_cnt[k] = 0;
            end else if (hit && exp_cnt[k] < maxc) begin
                exp_cnt[k] = exp_cnt[k] + 1;
            end
            if (v && ir[k]) begin
                if (k == 3)       e = ref_y(av, WD[k], INV[k]);
                else if (use_tab) e = INV[k] ? t_nor : t_or;
                else              e = ref_y(av, WD[k], INV[k]);
                sb[k].push_back('{y: e, t: cyc});
            end
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 32'd0, ordy, 1'b0, 1'b0, 4'd0, 4'd0);
        end
    endtask

    // Called at a falling edge: asserts reset well away from the rising edge.
    task automatic check_reset_state();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("inst%0d reset out_valid", k), {31'd0, ov[k]}, 32'd0);
            check($sformatf("inst%0d reset y", k), {28'd0, y[k]}, 32'd0);
            check($sformatf("inst%0d reset evt_cnt", k), {24'd0, cnt[k]}, 32'd0);
            sb[k].delete();
            exp_cnt[k] = 0;
        end
    endtask

    function automatic logic [31:0] rand_a();
        logic [31:0] r;
        r = $urandom;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 0) r[i * 8 +: 8] = 8'h00;
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        logic [31:0] beat_a;
        logic [3:0]  bp_pat;

        tab[0] = '{32'h0000_0000, 4'b1111, 4'b0000};
        tab[1] = '{32'h0000_0100, 4'b1101, 4'b0010};
        tab[2] = '{32'h8000_0001, 4'b0110, 4'b1001};
        tab[3] = '{32'hFFFF_FFFF, 4'b0000, 4'b1111};
        tab[4] = '{32'h00FF_0000, 4'b1011, 4'b0100};
        tab[5] = '{32'h1234_0000, 4'b0011, 4'b1100};
        tab[6] = '{32'h0000_0010, 4'b1110, 4'b0001};
        tab[7] = '{32'h0000_4000, 4'b1101, 4'b0010};
        tab[8] = '{32'h0080_0000, 4'b1011, 4'b0100};
        tab[9] = '{32'h0100_0080, 4'b0110, 4'b1001};

        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        lat_on = 1'b1;
        RST = 1'b1;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        CLR_CNT = 1'b0;
        a = '0;

        // Power-on reset state.
        @(negedge CLK);
        #1;
        check_reset_state();
        @(negedge CLK);
        RST = 1'b0;

        // Table vectors, back to back, with the output always taken.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tab[i].a, 1'b1, 1'b0, 1'b1, tab[i].y_nor, tab[i].y_or);
        end
        idle(6, 1'b1);

        // Counter: clear, then five qualifying beats (CNT_W=2 runs 1,2,3,3,3).
        step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        end
        idle(6, 1'b1);
        // Clear coinciding with output transfers.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h0000_0000, 1'b1, (i == 3), 1'b0, 4'd0, 4'd0);
        end
        idle(6, 1'b1);

        // Backpressure: 8 beats into the default instance, OUT_READY 1,0,0,1...
        lat_on = 1'b0;
        bp_pat = 4'b1001;
        sent = 0;
        beat_a = rand_a();
        for (int c = 0; c < 80 && sent < 8; c++) begin
            step(1'b1, beat_a, bp_pat[c % 4], 1'b0, 1'b0, 4'd0, 4'd0);
            if (acc0) begin
                sent++;
                beat_a = rand_a();
            end
        end
        check("backpressure beats accepted", sent, 8);
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 32'd0, bp_pat[c % 4], 1'b0, 1'b0, 4'd0, 4'd0);
        end
        idle(6, 1'b1);

        // Reset with two beats in flight: nothing may emerge afterwards.
        lat_on = 1'b1;
        step(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 32'h00FF_0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        IN_VALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check_reset_state();
        @(negedge CLK);
        RST = 1'b0;
        idle(8, 1'b1);

        // Random traffic with random stalls and occasional clears.
        lat_on = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 3) != 0, rand_a(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 14) == 0, 1'b0, 4'd0, 4'd0);
        end
        idle(10, 1'b1);

        for (int k = 0; k < NI; k++) begin
            check($sformatf("inst%0d beats outstanding", k), sb[k].size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
